// File: rtl/digit_bus_pkg.sv
// Shared definitions for the time-multiplexed digit bus: field widths and the
// packed {sel,nibble} word that travels on it.
package digit_bus_pkg;

    localparam int SEL_W      = 3;
    localparam int NIB_W      = 4;
    localparam int WORD_W     = SEL_W + NIB_W;
    localparam int MAX_DIGITS = 8;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [NIB_W-1:0] nib;
    } bus_word_t;

    // True when a bus position addresses one of the assembled digits.
    function automatic logic sel_in_range(input logic [SEL_W-1:0] s, input int digits);
        logic [SEL_W:0] limit;
        limit = (SEL_W+1)'(digits);
        return ({1'b0, s} < limit);
    endfunction

endpackage

// File: rtl/mux_stable_det.sv
// Bus stability detector: samples the {sel,nibble} word every clock and strobes
// accept exactly once when the same word has been seen on SETTLE+1 edges in a row.
module mux_stable_det
    import digit_bus_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_i,
    output logic              accept_o,
    output logic [WORD_W-1:0] word_o
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    logic [WORD_W-1:0] s_q;
    logic [WORD_W-1:0] s_d;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic              same;

    assign same = (word_i == s_q);

    // Counter saturates at SETTLE so a bus held forever accepts only once.
    always_comb begin
        s_d   = word_i;
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = 8'd0;
        end else if (cnt_q < SETTLE_C) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            cnt_q <= 8'd0;
        end else begin
            s_q   <= s_d;
            cnt_q <= cnt_d;
        end
    end

    assign accept_o = same && (cnt_q == (SETTLE_C - 8'd1));
    assign word_o   = word_i;

endmodule

// File: rtl/mux_digit_receiver.sv
// Receiving end of the multiplexed digit bus: assembles settled digits into a
// multi-digit value and announces a frame once every position has been refreshed.
module mux_digit_receiver
    import digit_bus_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            din,
    input  logic [2:0]            sel,
    output logic [4*DIGITS-1:0]   live,
    output logic [4*DIGITS-1:0]   value,
    output logic                  frame_valid,
    output logic                  dup_err
);

    logic              accept;
    logic [WORD_W-1:0] acc_raw;
    bus_word_t         acc_word;
    logic              acc_valid;

    logic [4*DIGITS-1:0] live_q;
    logic [4*DIGITS-1:0] live_d;
    logic [4*DIGITS-1:0] value_q;
    logic [4*DIGITS-1:0] value_d;
    logic [DIGITS-1:0]   seen_q;
    logic [DIGITS-1:0]   seen_d;
    logic [DIGITS-1:0]   hit;
    logic [DIGITS-1:0]   merged;
    logic                frame_valid_q;
    logic                frame_valid_d;
    logic                dup_err_q;
    logic                dup_err_d;
    logic [NIB_W-1:0]    cur_nib;

    mux_stable_det #(
        .SETTLE (SETTLE)
    ) u_stable_det (
        .clk      (clk),
        .rst      (rst),
        .word_i   ({sel, din}),
        .accept_o (accept),
        .word_o   (acc_raw)
    );

    assign acc_word  = bus_word_t'(acc_raw);
    assign acc_valid = accept && sel_in_range(acc_word.sel, DIGITS);

    // One decoded write strobe and next-value slice per digit position.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pos
        assign hit[gi] = acc_valid && (acc_word.sel == SEL_W'(gi));
        assign live_d[4*gi +: 4] = hit[gi] ? acc_word.nib : live_q[4*gi +: 4];
    end

    always_comb begin
        cur_nib = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_word.sel == SEL_W'(k)) begin
                cur_nib = live_q[4*k +: 4];
            end
        end
    end

    assign merged = seen_q | hit;

    // Frame state lives in seen: any bit set means collecting, all-clear means empty.
    always_comb begin
        seen_d        = seen_q;
        value_d       = value_q;
        frame_valid_d = 1'b0;
        dup_err_d     = 1'b0;
        if (acc_valid) begin
            if (((seen_q & hit) != '0) && (cur_nib != acc_word.nib)) begin
                dup_err_d = 1'b1;
            end
            if (&merged) begin
                value_d       = live_d;
                frame_valid_d = 1'b1;
                seen_d        = '0;
            end else begin
                seen_d = merged;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q        <= '0;
            value_q       <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            dup_err_q     <= 1'b0;
        end else begin
            live_q        <= live_d;
            value_q       <= value_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            dup_err_q     <= dup_err_d;
        end
    end

    assign live        = live_q;
    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign dup_err     = dup_err_q;

endmodule

// File: tb/tb_mux_digit_receiver.sv
// Bench for mux_digit_receiver: directed segment table plus randomized bus
// traffic compared edge-by-edge against a run-length reference model.
module tb_mux_digit_receiver;

    localparam int DIGITS = 2;
    localparam int SETTLE = 4;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [2:0] sel;
    logic [7:0] live;
    logic [7:0] value;
    logic       frame_valid;
    logic       dup_err;

    int n_checks = 0;
    int n_errors = 0;
    int fv_cnt;
    int dup_cnt;

    mux_digit_receiver #(
        .DIGITS (DIGITS),
        .SETTLE (SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .sel         (sel),
        .live        (live),
        .value       (value),
        .frame_valid (frame_valid),
        .dup_err     (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counts how many consecutive edges carried the same word.
    logic [2:0] m_prev_sel;
    logic [3:0] m_prev_din;
    int         m_run;
    logic [3:0] m_live [DIGITS];
    bit         m_seen [DIGITS];
    logic [7:0] m_value;
    bit         m_fv;
    bit         m_dup;

    function automatic logic [7:0] m_pack();
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = m_live[k];
        return r;
    endfunction

    task automatic model_reset();
        m_prev_sel = 3'd0;
        m_prev_din = 4'd0;
        m_run      = 1;
        m_value    = '0;
        m_fv       = 0;
        m_dup      = 0;
        for (int k = 0; k < DIGITS; k++) begin
            m_live[k] = 4'd0;
            m_seen[k] = 0;
        end
    endtask

    task automatic model_edge(input logic [2:0] s, input logic [3:0] d);
        bit all_seen;
        m_fv  = 0;
        m_dup = 0;
        if (s == m_prev_sel && d == m_prev_din) m_run++;
        else m_run = 1;
        m_prev_sel = s;
        m_prev_din = d;
        if (m_run == SETTLE + 1 && int'(s) < DIGITS) begin
            if (m_seen[s] && m_live[s] != d) m_dup = 1;
            m_live[s] = d;
            m_seen[s] = 1;
            all_seen = 1;
            for (int k = 0; k < DIGITS; k++) if (!m_seen[k]) all_seen = 0;
            if (all_seen) begin
                m_value = m_pack();
                m_fv    = 1;
                for (int k = 0; k < DIGITS; k++) m_seen[k] = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        sel = 3'd0;
        din = 4'd0;
        rst = 1'b1;
        #2;
        chk("async_rst_live", 32'(live), 32'h0);
        chk("async_rst_value", 32'(value), 32'h0);
        chk("async_rst_flags", 32'({frame_valid, dup_err}), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        $display("reset applied");
    endtask

    task automatic step(input logic [2:0] s, input logic [3:0] d);
        sel = s;
        din = d;
        @(posedge clk);
        model_edge(s, d);
        #1;
        chk("model_live", 32'(live), 32'(m_pack()));
        chk("model_value", 32'(value), 32'(m_value));
        chk("model_frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("model_dup_err", 32'(dup_err), 32'(m_dup));
        if (frame_valid === 1'b1) fv_cnt++;
        if (dup_err === 1'b1) dup_cnt++;
    endtask

    typedef struct {
        bit         do_rst;
        logic [2:0] sel;
        logic [3:0] din;
        int         hold;
        logic [7:0] exp_live;
        logic [7:0] exp_value;
        int         exp_fv;
        int         exp_dup;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [2:0] s, logic [3:0] d, int h,
                                logic [7:0] el, logic [7:0] ev, int ef, int ed);
        vec_t v;
        v.do_rst = r; v.sel = s; v.din = d; v.hold = h;
        v.exp_live = el; v.exp_value = ev; v.exp_fv = ef; v.exp_dup = ed;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        sel = 3'd0;
        din = 4'd0;
        #3;
        chk("reset_live", 32'(live), 32'h0);
        chk("reset_value", 32'(value), 32'h0);
        chk("reset_frame_valid", 32'(frame_valid), 32'h0);
        chk("reset_dup_err", 32'(dup_err), 32'h0);

        // Two digits accepted -> frame A5
        vecs.push_back(mk(1, 3'd0, 4'h5,   5, 8'h05, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd1, 4'hA,   5, 8'hA5, 8'hA5, 1, 0));
        // Too short, then out-of-range position, then sel=1 alone: no frame
        vecs.push_back(mk(1, 3'd0, 4'h3,   4, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd5, 4'h7,  20, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd1, 4'h4,   5, 8'h40, 8'h00, 0, 0));
        // Conflicting re-accept
        vecs.push_back(mk(1, 3'd0, 4'h1,   5, 8'h01, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd0, 4'h2,   5, 8'h02, 8'h00, 0, 1));
        vecs.push_back(mk(0, 3'd1, 4'h0,   5, 8'h02, 8'h02, 1, 0));
        // Equal re-accept is silent
        vecs.push_back(mk(1, 3'd0, 4'h6,   5, 8'h06, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd2, 4'h0,   1, 8'h06, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd0, 4'h6,   5, 8'h06, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd1, 4'h3,   5, 8'h36, 8'h36, 1, 0));
        // Reset discards partial frame
        vecs.push_back(mk(1, 3'd0, 4'h9,   5, 8'h09, 8'h00, 0, 0));
        vecs.push_back(mk(1, 3'd1, 4'h4,   5, 8'h40, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd0, 4'h9,   5, 8'h49, 8'h49, 1, 0));
        // Long hold accepts exactly once
        vecs.push_back(mk(1, 3'd0, 4'h8, 100, 8'h08, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd1, 4'h8,   5, 8'h88, 8'h88, 1, 0));
        // Latency: not after SETTLE edges, yes after SETTLE+1
        vecs.push_back(mk(1, 3'd0, 4'h5,   4, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd0, 4'h5,   1, 8'h05, 8'h00, 0, 0));
        // Bus at {0,0} through reset release counts the reset sample
        vecs.push_back(mk(1, 3'd0, 4'h0,   4, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(0, 3'd1, 4'h1,   5, 8'h10, 8'h10, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) apply_reset();
            fv_cnt  = 0;
            dup_cnt = 0;
            for (int e = 0; e < vecs[i].hold; e++) step(vecs[i].sel, vecs[i].din);
            chk($sformatf("vec%0d_live", i), 32'(live), 32'(vecs[i].exp_live));
            chk($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].exp_value));
            chk($sformatf("vec%0d_fv_pulses", i), 32'(fv_cnt), 32'(vecs[i].exp_fv));
            chk($sformatf("vec%0d_dup_pulses", i), 32'(dup_cnt), 32'(vecs[i].exp_dup));
            $display("vec %0d sel=%0d din=%0h hold=%0d live=%02h value=%02h fv=%0d dup=%0d",
                     i, vecs[i].sel, vecs[i].din, vecs[i].hold, live, value, fv_cnt, dup_cnt);
        end

        // Random bus traffic against the model, with occasional mid-frame resets
        apply_reset();
        for (int seg = 0; seg < 400; seg++) begin
            logic [2:0] rs;
            logic [3:0] rd;
            int         rh;
            if ($urandom_range(0, 39) == 0) apply_reset();
            rs = 3'($urandom_range(0, 3));
            rd = 4'($urandom_range(0, 3));
            rh = $urandom_range(1, 8);
            fv_cnt  = 0;
            dup_cnt = 0;
            for (int e = 0; e < rh; e++) step(rs, rd);
            $display("rand %0d sel=%0d din=%0h hold=%0d live=%02h value=%02h fv=%0d dup=%0d",
                     seg, rs, rd, rh, live, value, fv_cnt, dup_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
